// File: rtl/pipe_ex_if.sv
// pipe_ex_if: bundle between the ID stage, the EX stage and the EX/MEM register.
//   ID* signals : decoded instruction presented by the ID stage
//   EX* signals : execute-stage result bundle handed to the memory stage
// Modports:
//   master : the ID-stage side (drives ID*, observes EX*)
//   slave  : the execute stage pipe_ex (consumes ID*, drives EX*)
interface pipe_ex_if #(
  parameter int WIDTH  = 32,
  parameter int RWIDTH = 5
);
  logic              IDwreg;
  logic              IDm2reg;
  logic              IDwmem;
  logic [3:0]        IDaluc;
  logic              IDshift;
  logic              IDaluimm;
  logic [RWIDTH-1:0] IDwn;
  logic [WIDTH-1:0]  IDqa;
  logic [WIDTH-1:0]  IDqb;
  logic [WIDTH-1:0]  IDimmeOrSa;

  logic              EXvalid;
  logic              EXwreg;
  logic              EXm2reg;
  logic              EXwmem;
  logic [RWIDTH-1:0] EXwn;
  logic [WIDTH-1:0]  EXalu;
  logic [WIDTH-1:0]  EXqb;
  logic              EXz;

  modport master (
    output IDwreg, IDm2reg, IDwmem, IDaluc, IDshift, IDaluimm,
           IDwn, IDqa, IDqb, IDimmeOrSa,
    input  EXvalid, EXwreg, EXm2reg, EXwmem, EXwn, EXalu, EXqb, EXz
  );

  modport slave (
    input  IDwreg, IDm2reg, IDwmem, IDaluc, IDshift, IDaluimm,
           IDwn, IDqa, IDqb, IDimmeOrSa,
    output EXvalid, EXwreg, EXm2reg, EXwmem, EXwn, EXalu, EXqb, EXz
  );
endinterface

// File: rtl/pipe_ex.sv
// pipe_ex: execute stage of the 5-stage pipeline.
//   ID/EX pipeline register (stall = hold, flush = bubble, flush wins)
//   followed by a combinational ALU fed from the register.
// Ports:
//   clk   : pipeline clock, rising edge
//   clrn  : asynchronous active-low reset
//   stall : hold the ID/EX register
//   flush : load a bubble into the ID/EX register
//   bus   : pipe_ex_if slave modport (ID* in, EX* out)
module pipe_ex #(
  parameter int WIDTH  = 32,
  parameter int RWIDTH = 5
) (
  input  logic     clk,
  input  logic     clrn,
  input  logic     stall,
  input  logic     flush,
  pipe_ex_if.slave bus
);

  logic              valid_q,  valid_d;
  logic              wreg_q,   wreg_d;
  logic              m2reg_q,  m2reg_d;
  logic              wmem_q,   wmem_d;
  logic [3:0]        aluc_q,   aluc_d;
  logic              shift_q,  shift_d;
  logic              aluimm_q, aluimm_d;
  logic [RWIDTH-1:0] wn_q,     wn_d;
  logic [WIDTH-1:0]  qa_q,     qa_d;
  logic [WIDTH-1:0]  qb_q,     qb_d;
  logic [WIDTH-1:0]  imm_q,    imm_d;

  always_comb begin
    valid_d  = valid_q;
    wreg_d   = wreg_q;
    m2reg_d  = m2reg_q;
    wmem_d   = wmem_q;
    aluc_d   = aluc_q;
    shift_d  = shift_q;
    aluimm_d = aluimm_q;
    wn_d     = wn_q;
    qa_d     = qa_q;
    qb_d     = qb_q;
    imm_d    = imm_q;
    if (flush) begin
      // Bubble: everything zero, which the ALU evaluates as ADD 0+0.
      valid_d  = 1'b0;
      wreg_d   = 1'b0;
      m2reg_d  = 1'b0;
      wmem_d   = 1'b0;
      aluc_d   = 4'h0;
      shift_d  = 1'b0;
      aluimm_d = 1'b0;
      wn_d     = '0;
      qa_d     = '0;
      qb_d     = '0;
      imm_d    = '0;
    end else if (!stall) begin
      valid_d  = 1'b1;
      wreg_d   = bus.IDwreg;
      m2reg_d  = bus.IDm2reg;
      wmem_d   = bus.IDwmem;
      aluc_d   = bus.IDaluc;
      shift_d  = bus.IDshift;
      aluimm_d = bus.IDaluimm;
      wn_d     = bus.IDwn;
      qa_d     = bus.IDqa;
      qb_d     = bus.IDqb;
      imm_d    = bus.IDimmeOrSa;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q  <= 1'b0;
      wreg_q   <= 1'b0;
      m2reg_q  <= 1'b0;
      wmem_q   <= 1'b0;
      aluc_q   <= 4'h0;
      shift_q  <= 1'b0;
      aluimm_q <= 1'b0;
      wn_q     <= '0;
      qa_q     <= '0;
      qb_q     <= '0;
      imm_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      wreg_q   <= wreg_d;
      m2reg_q  <= m2reg_d;
      wmem_q   <= wmem_d;
      aluc_q   <= aluc_d;
      shift_q  <= shift_d;
      aluimm_q <= aluimm_d;
      wn_q     <= wn_d;
      qa_q     <= qa_d;
      qb_q     <= qb_d;
      imm_q    <= imm_d;
    end
  end

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] alu_r;

  always_comb begin
    alu_a = shift_q  ? imm_q : qa_q;
    alu_b = aluimm_q ? imm_q : qb_q;
    // Only the low five bits of operand A act as a shift distance.
    shamt = alu_a[4:0];
    alu_r = '0;
    casez (aluc_q)
      4'b?000: alu_r = alu_a + alu_b;
      4'b?100: alu_r = alu_a - alu_b;
      4'b?001: alu_r = alu_a & alu_b;
      4'b?101: alu_r = alu_a | alu_b;
      4'b?010: alu_r = alu_a ^ alu_b;
      4'b?110: alu_r = {alu_b[15:0], 16'h0000};
      4'b0011: alu_r = alu_b << shamt;
      4'b0111: alu_r = alu_b >> shamt;
      4'b1111: alu_r = $unsigned($signed(alu_b) >>> shamt);
      default: alu_r = '0;
    endcase
  end

  // Control bits are gated so a bubble can never write the register file or memory.
  assign bus.EXvalid = valid_q;
  assign bus.EXwreg  = valid_q & wreg_q;
  assign bus.EXm2reg = valid_q & m2reg_q;
  assign bus.EXwmem  = valid_q & wmem_q;
  assign bus.EXwn    = wn_q;
  assign bus.EXqb    = qb_q;
  assign bus.EXalu   = alu_r;
  assign bus.EXz     = (alu_r == '0);

endmodule

// File: tb/tb_pipe_ex.sv
module tb_pipe_ex;

  logic clk;
  logic clrn;
  logic stall;
  logic flush;

  pipe_ex_if #(.WIDTH(32), .RWIDTH(5)) bus ();

  pipe_ex #(.WIDTH(32), .RWIDTH(5)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents of the ID/EX register as the spec describes it.
  logic        m_valid, m_wreg, m_m2reg, m_wmem, m_shift, m_aluimm;
  logic [3:0]  m_aluc;
  logic [4:0]  m_wn;
  logic [31:0] m_qa, m_qb, m_imm;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    sh = a % 32;
    fill = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    if (op == 4'b0011) return b << sh;
    if (op == 4'b0111) return b >> sh;
    if (op == 4'b1111) return (b >> sh) | fill;
    if (op == 4'b1011) return 32'h0;
    case (op[2:0])
      3'b000:  return a + b;
      3'b100:  return a - b;
      3'b001:  return a & b;
      3'b101:  return a | b;
      3'b010:  return a ^ b;
      3'b110:  return b * 32'd65536;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wreg = 0; m_m2reg = 0; m_wmem = 0; m_shift = 0; m_aluimm = 0;
    m_aluc = 0; m_wn = 0; m_qa = 0; m_qb = 0; m_imm = 0;
  endtask

  task automatic model_edge();
    if (flush) model_reset();
    else if (!stall) begin
      m_valid = 1; m_wreg = bus.IDwreg; m_m2reg = bus.IDm2reg; m_wmem = bus.IDwmem;
      m_shift = bus.IDshift; m_aluimm = bus.IDaluimm; m_aluc = bus.IDaluc;
      m_wn = bus.IDwn; m_qa = bus.IDqa; m_qb = bus.IDqb; m_imm = bus.IDimmeOrSa;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] a, b, r;
    a = m_shift ? m_imm : m_qa;
    b = m_aluimm ? m_imm : m_qb;
    r = ref_alu(m_aluc, a, b);
    chk({tag, ".valid"}, 32'(bus.EXvalid), 32'(m_valid));
    chk({tag, ".wreg"},  32'(bus.EXwreg),  32'(m_valid & m_wreg));
    chk({tag, ".m2reg"}, 32'(bus.EXm2reg), 32'(m_valid & m_m2reg));
    chk({tag, ".wmem"},  32'(bus.EXwmem),  32'(m_valid & m_wmem));
    chk({tag, ".wn"},    32'(bus.EXwn),    32'(m_wn));
    chk({tag, ".qb"},    bus.EXqb,         m_qb);
    chk({tag, ".alu"},   bus.EXalu,        r);
    chk({tag, ".z"},     32'(bus.EXz),     32'(r == 32'h0));
  endtask

  task automatic set_id(input logic wreg, input logic m2reg, input logic wmem,
                        input logic [3:0] aluc, input logic shift, input logic aluimm,
                        input logic [4:0] wn, input logic [31:0] qa, input logic [31:0] qb,
                        input logic [31:0] imm);
    bus.IDwreg = wreg; bus.IDm2reg = m2reg; bus.IDwmem = wmem; bus.IDaluc = aluc;
    bus.IDshift = shift; bus.IDaluimm = aluimm; bus.IDwn = wn;
    bus.IDqa = qa; bus.IDqb = qb; bus.IDimmeOrSa = imm;
  endtask

  task automatic rand_id();
    set_id(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
           1'($urandom), 5'($urandom), $urandom, $urandom,
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
  endtask

  // One rising edge; model updated from the inputs present at the edge, outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    stall = 0; flush = 0; clrn = 1;
    rand_id();
    #1 clrn = 0;
    model_reset();
    #2;
    chk("rst.valid", 32'(bus.EXvalid), 32'h0);
    chk("rst.wreg",  32'(bus.EXwreg),  32'h0);
    chk("rst.wmem",  32'(bus.EXwmem),  32'h0);
    chk("rst.alu",   bus.EXalu,        32'h0);
    chk("rst.z",     32'(bus.EXz),     32'h1);
    check_model("rst");
    @(negedge clk);
    @(negedge clk);
    clrn = 1;

    set_id(1, 0, 0, 4'b0000, 0, 0, 5'd3, 32'h7FFF_FFFF, 32'h1, 32'h0);
    step();
    chk("add.alu", bus.EXalu, 32'h8000_0000);
    chk("add.z", 32'(bus.EXz), 32'h0);
    check_model("add");

    set_id(1, 0, 0, 4'b0100, 0, 0, 5'd4, 32'd5, 32'd5, 32'h0);
    step();
    chk("sub.alu", bus.EXalu, 32'h0);
    chk("sub.z", 32'(bus.EXz), 32'h1);
    check_model("sub");

    set_id(1, 0, 0, 4'b0000, 0, 1, 5'd5, 32'd10, 32'h55, 32'hFFFF_FFFC);
    step();
    chk("addi.alu", bus.EXalu, 32'd6);
    check_model("addi");

    set_id(1, 0, 0, 4'b0110, 0, 1, 5'd6, 32'd10, 32'h55, 32'h0000_1234);
    step();
    chk("lui.alu", bus.EXalu, 32'h1234_0000);
    check_model("lui");

    set_id(1, 0, 0, 4'b0011, 1, 0, 5'd8, 32'hFFFF_FFFF, 32'h8000_0010, 32'd4);
    step();
    chk("sll.alu", bus.EXalu, 32'h0000_0100);
    bus.IDaluc = 4'b0111;
    step();
    chk("srl.alu", bus.EXalu, 32'h0800_0001);
    bus.IDaluc = 4'b1111;
    step();
    chk("sra.alu", bus.EXalu, 32'hF800_0001);
    check_model("sra");
    bus.IDimmeOrSa = 32'h0;
    step();
    chk("sra0.alu", bus.EXalu, 32'h8000_0010);
    bus.IDaluc = 4'b0011;
    step();
    chk("sll0.alu", bus.EXalu, 32'h8000_0010);
    bus.IDimmeOrSa = 32'h0000_0FE4;   // upper bits ignored: shift by 4
    bus.IDaluc = 4'b0111;
    step();
    chk("srl_hi.alu", bus.EXalu, 32'h0800_0001);
    bus.IDaluc = 4'b1011;
    step();
    chk("unused.alu", bus.EXalu, 32'h0);
    chk("unused.z", 32'(bus.EXz), 32'h1);

    set_id(1, 0, 0, 4'b0000, 0, 0, 5'd7, 32'd3, 32'd4, 32'h0);
    step();
    chk("ld.alu", bus.EXalu, 32'd7);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step();
      chk("stall.wreg", 32'(bus.EXwreg), 32'h1);
      chk("stall.wn", 32'(bus.EXwn), 32'd7);
      chk("stall.alu", bus.EXalu, 32'd7);
      check_model("stall");
    end
    stall = 0;
    set_id(0, 1, 0, 4'b0101, 0, 0, 5'd9, 32'hF0, 32'h0F, 32'h0);
    step();
    chk("unstall.alu", bus.EXalu, 32'hFF);
    chk("unstall.wn", 32'(bus.EXwn), 32'd9);
    chk("unstall.m2reg", 32'(bus.EXm2reg), 32'h1);

    set_id(0, 0, 1, 4'b0000, 0, 1, 5'd2, 32'd100, 32'h0000_DEAD, 32'd8);
    stall = 1; flush = 1;
    step();
    chk("flush.valid", 32'(bus.EXvalid), 32'h0);
    chk("flush.wmem", 32'(bus.EXwmem), 32'h0);
    chk("flush.wreg", 32'(bus.EXwreg), 32'h0);
    chk("flush.qb", bus.EXqb, 32'h0);
    chk("flush.alu", bus.EXalu, 32'h0);
    chk("flush.z", 32'(bus.EXz), 32'h1);
    stall = 0; flush = 0;
    step();
    chk("store.wmem", 32'(bus.EXwmem), 32'h1);
    chk("store.qb", bus.EXqb, 32'h0000_DEAD);
    check_model("store");

    stall = 1;
    #2 clrn = 0;
    model_reset();
    #1;
    chk("arst.valid", 32'(bus.EXvalid), 32'h0);
    chk("arst.wmem", 32'(bus.EXwmem), 32'h0);
    chk("arst.qb", bus.EXqb, 32'h0);
    chk("arst.z", 32'(bus.EXz), 32'h1);
    #1 clrn = 1;
    stall = 0;

    for (int i = 0; i < 400; i++) begin
      rand_id();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 6) == 0);
      step();
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ex.md
Name: pipe_ex

Overview:
- Execute stage of the 5-stage pipelined CPU; consumes the ID-stage output bundle (control bits, operands, destination register, immediate/shift amount).
- Contains the ID/EX pipeline register, with stall (hold) and flush (bubble) control, followed by the ALU.
- Presents the EX-stage result bundle to the EX/MEM register of the memory stage.
- The registered control bits travel forward; wreg/wn eventually return to the register file as WBwreg/WBwn.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- RWIDTH, 5, register-number width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- clrn  in  1  reset; asynchronous and active-low.
- stall  in  1  hazard unit: hold the ID/EX register contents.
- flush  in  1  hazard unit: load a bubble into the ID/EX register.
- IDwreg  in  1  ID: register-file write enable.
- IDm2reg  in  1  ID: write-back selects memory data.
- IDwmem  in  1  ID: data-memory write enable.
- IDaluc  in  4  ID: ALU operation code.
- IDshift  in  1  ID: operand A comes from IDimmeOrSa (shift amount).
- IDaluimm  in  1  ID: operand B comes from IDimmeOrSa (immediate).
- IDwn  in  RWIDTH  ID: destination register number.
- IDqa  in  WIDTH  ID: register operand A.
- IDqb  in  WIDTH  ID: register operand B.
- IDimmeOrSa  in  WIDTH  ID: extended immediate or zero-extended shift amount.
- EXvalid  out  1  registered stage holds a real instruction (0 = bubble).
- EXwreg  out  1  registered wreg, gated by valid.
- EXm2reg  out  1  registered m2reg, gated by valid.
- EXwmem  out  1  registered wmem, gated by valid.
- EXwn  out  RWIDTH  registered destination register.
- EXalu  out  WIDTH  ALU result.
- EXqb  out  WIDTH  registered qb, used as store data.
- EXz  out  1  EXalu equals zero.

Behaviour:
- Reset (clrn=0, asynchronous): all ID/EX fields cleared, valid=0.
  - Outputs during and after reset until the first load: EXvalid=0, EXwreg=0, EXm2reg=0, EXwmem=0, EXwn=0, EXqb=0, EXalu=0, EXz=1.
- ID/EX register update at each rising clk edge, in priority order:
  - flush=1: control fields (wreg, m2reg, wmem, shift, aluimm) cleared, aluc=0, data fields cleared, valid=0. Flush overrides stall.
  - stall=1 and flush=0: every field holds its value.
  - otherwise: all ID* inputs captured and valid=1.
- Latency: ID* inputs present before edge N appear on EX* outputs after edge N. Outputs are combinational from the register; the block has no second register stage.
- Reset asserted mid-operation discards the in-flight instruction immediately. Reset release takes effect with the next normal edge.
- Output gating:
  - EXwreg = valid & wreg; EXm2reg = valid & m2reg; EXwmem = valid & wmem.
  - A bubble therefore never writes the register file or memory.
- Operand selection:
  - a = shift ? immeOrSa : qa.
  - b = aluimm ? immeOrSa : qb.
- ALU (aluc[3:0]), all arithmetic modulo 2^WIDTH, no overflow trap, no flags other than EXz:
  - x000 ADD: a+b.
  - x100 SUB: a-b.
  - x001 AND.
  - x101 OR.
  - x010 XOR.
  - x110 LUI: {b[15:0],16'h0000}.
  - 0011 SLL: b << a[4:0].
  - 0111 SRL: b >> a[4:0], logical.
  - 1111 SRA: b >>> a[4:0], arithmetic; sign bit b[31] replicated.
  - 1011 (unused code): result 0.
- Shifts by 0 return b unchanged. Only a[4:0] is used as the shift amount; upper bits are ignored.
- EXz = (EXalu == 0), evaluated for bubbles too. Bubble result is ADD 0+0, so EXz=1.
- Simultaneous stall and flush: flush wins and a bubble is loaded.

Test Plan:
- Reset: clrn=0 with random ID* inputs, no clock edge -> EXvalid=0, EXwreg=0, EXwmem=0, EXalu=0, EXz=1. Drop clrn=0 asynchronously mid-cycle while a valid instruction is held -> outputs clear immediately.
- ADD/SUB: IDqa=32'h7FFFFFFF, IDqb=1, aluc=0000, edge -> EXalu=32'h80000000, EXz=0. Then aluc=0100 with qa=qb=5 -> EXalu=0, EXz=1.
- Immediate and LUI: aluimm=1, IDimmeOrSa=32'hFFFFFFFC, IDqa=10, aluc=0000 -> EXalu=6. aluc=0110, IDimmeOrSa=32'h00001234 -> EXalu=32'h12340000.
- Shifts: shift=1, IDimmeOrSa=4, IDqb=32'h80000010.
  - aluc=0011 -> 32'h00000100.
  - aluc=0111 -> 32'h08000001.
  - aluc=1111 -> 32'hF8000001.
  - IDimmeOrSa=0 -> 32'h80000010.
- Stall: load wreg=1, wn=7, ADD 3+4 (EXalu=7). Raise stall for 3 edges while ID* inputs change -> EX* outputs stay wreg=1, wn=7, EXalu=7. Release stall -> next edge captures the new inputs.
- Flush: valid store instruction (wmem=1, qb=32'hDEAD) with flush=1 and stall=1 on the same edge -> EXvalid=0, EXwmem=0, EXwreg=0, EXqb=0, EXalu=0.
